// File: rtl/mem_arbiter.sv
// Three-port arbiter (data > instruction > host) in front of a single-port memory
// with fixed read latency; one transaction in flight, with starvation relief for fetches.
module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_valid,

    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wr_data,
    output logic [31:0] d_rd_data,
    output logic        d_valid,

    input  logic        h_rd,
    input  logic        h_wr,
    input  logic [31:0] h_addr,
    input  logic [31:0] h_wr_data,
    output logic [31:0] h_rd_data,
    output logic        h_valid,

    output logic [31:0] m_addr,
    output logic [31:0] m_wr_data,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [31:0] m_rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PORT_I = 2'd0,
        PORT_D = 2'd1,
        PORT_H = 2'd2
    } port_t;

    localparam int             SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [3:0]     LAT        = 4'(MEM_LAT);

    state_t        state_q, state_d;
    port_t         port_q, port_d;
    logic          wr_q, wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   i_data_q, i_data_d;
    logic [31:0]   d_rd_data_q, d_rd_data_d;
    logic [31:0]   h_rd_data_q, h_rd_data_d;

    logic d_req;
    logic h_req;
    logic i_wins;

    assign d_req  = d_rd | d_wr;
    assign h_req  = h_rd | h_wr;
    // Fetch beats data only once it has lost STARVE_MAX arbitrations in a row.
    assign i_wins = i_req && (!d_req || (starve_q == STARVE_LIM));

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        starve_d    = starve_q;
        cnt_d       = cnt_q;
        i_data_d    = i_data_q;
        d_rd_data_d = d_rd_data_q;
        h_rd_data_d = h_rd_data_q;

        case (state_q)
            IDLE: begin
                if (i_req || d_req || h_req) begin
                    state_d = ISSUE;
                    if (i_wins) begin
                        port_d   = PORT_I;
                        wr_d     = 1'b0;
                        addr_d   = i_addr;
                        starve_d = '0;
                    end else if (d_req) begin
                        port_d  = PORT_D;
                        wr_d    = d_wr;
                        addr_d  = d_addr;
                        wdata_d = d_wr_data;
                        if (i_req && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else begin
                        port_d  = PORT_H;
                        wr_d    = h_wr;
                        addr_d  = h_addr;
                        wdata_d = h_wr_data;
                    end
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 4'd1;
                end
            end
            WAIT: begin
                // Memory sampled m_rd at the end of ISSUE; its data lands MEM_LAT edges later.
                if (cnt_q == LAT) begin
                    state_d = DONE;
                    case (port_q)
                        PORT_I:  i_data_d    = m_rd_data;
                        PORT_D:  d_rd_data_d = m_rd_data;
                        default: h_rd_data_d = m_rd_data;
                    endcase
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            port_q      <= PORT_I;
            wr_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            starve_q    <= '0;
            cnt_q       <= 4'd0;
            i_data_q    <= 32'h0;
            d_rd_data_q <= 32'h0;
            h_rd_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            cnt_q       <= cnt_d;
            i_data_q    <= i_data_d;
            d_rd_data_q <= d_rd_data_d;
            h_rd_data_q <= h_rd_data_d;
        end
    end

    // Latched command registers double as the memory bus, so it holds between accesses.
    assign m_addr    = addr_q;
    assign m_wr_data = wdata_q;
    assign m_rd      = (state_q == ISSUE) && !wr_q;
    assign m_wr      = (state_q == ISSUE) && wr_q;

    assign i_data    = i_data_q;
    assign d_rd_data = d_rd_data_q;
    assign h_rd_data = h_rd_data_q;
    assign i_valid   = (state_q == DONE) && (port_q == PORT_I);
    assign d_valid   = (state_q == DONE) && (port_q == PORT_D);
    assign h_valid   = (state_q == DONE) && (port_q == PORT_H);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default instance (MEM_LAT=2, STARVE_MAX=8)
// and a MEM_LAT=1, STARVE_MAX=0 instance, each with a latency-exact memory model.
module tb_mem_arbiter;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A3C, a[15:0]};
    endfunction

    // ---------------- instance A: defaults ----------------
    logic        a_rst_n = 1'b1;
    logic        a_i_req = 1'b0;
    logic [31:0] a_i_addr = 32'h0;
    logic [31:0] a_i_data;
    logic        a_i_valid;
    logic        a_d_rd = 1'b0, a_d_wr = 1'b0;
    logic [31:0] a_d_addr = 32'h0, a_d_wr_data = 32'h0;
    logic [31:0] a_d_rd_data;
    logic        a_d_valid;
    logic        a_h_rd = 1'b0, a_h_wr = 1'b0;
    logic [31:0] a_h_addr = 32'h0, a_h_wr_data = 32'h0;
    logic [31:0] a_h_rd_data;
    logic        a_h_valid;
    logic [31:0] a_m_addr, a_m_wr_data, a_m_rd_data;
    logic        a_m_rd, a_m_wr;

    mem_arbiter dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_data(a_i_data), .i_valid(a_i_valid),
        .d_rd(a_d_rd), .d_wr(a_d_wr), .d_addr(a_d_addr), .d_wr_data(a_d_wr_data),
        .d_rd_data(a_d_rd_data), .d_valid(a_d_valid),
        .h_rd(a_h_rd), .h_wr(a_h_wr), .h_addr(a_h_addr), .h_wr_data(a_h_wr_data),
        .h_rd_data(a_h_rd_data), .h_valid(a_h_valid),
        .m_addr(a_m_addr), .m_wr_data(a_m_wr_data), .m_rd(a_m_rd), .m_wr(a_m_wr),
        .m_rd_data(a_m_rd_data)
    );

    logic [31:0] a_pipe0 = JUNK, a_pipe1 = JUNK;
    logic [31:0] a_wr_addr = 32'h0, a_wr_data = 32'h0;
    always @(posedge clk) begin
        a_pipe0 <= a_m_rd ? memval(a_m_addr) : JUNK;
        a_pipe1 <= a_pipe0;
        if (a_m_wr) begin
            a_wr_addr <= a_m_addr;
            a_wr_data <= a_m_wr_data;
        end
    end
    assign a_m_rd_data = a_pipe1;

    // ---------------- instance B: MEM_LAT=1, STARVE_MAX=0 ----------------
    logic        b_rst_n = 1'b1;
    logic        b_i_req = 1'b0;
    logic [31:0] b_i_addr = 32'h0;
    logic [31:0] b_i_data;
    logic        b_i_valid;
    logic        b_d_rd = 1'b0, b_d_wr = 1'b0;
    logic [31:0] b_d_addr = 32'h0, b_d_wr_data = 32'h0;
    logic [31:0] b_d_rd_data;
    logic        b_d_valid;
    logic        b_h_rd = 1'b0, b_h_wr = 1'b0;
    logic [31:0] b_h_addr = 32'h0, b_h_wr_data = 32'h0;
    logic [31:0] b_h_rd_data;
    logic        b_h_valid;
    logic [31:0] b_m_addr, b_m_wr_data, b_m_rd_data;
    logic        b_m_rd, b_m_wr;

    mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(0)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_data(b_i_data), .i_valid(b_i_valid),
        .d_rd(b_d_rd), .d_wr(b_d_wr), .d_addr(b_d_addr), .d_wr_data(b_d_wr_data),
        .d_rd_data(b_d_rd_data), .d_valid(b_d_valid),
        .h_rd(b_h_rd), .h_wr(b_h_wr), .h_addr(b_h_addr), .h_wr_data(b_h_wr_data),
        .h_rd_data(b_h_rd_data), .h_valid(b_h_valid),
        .m_addr(b_m_addr), .m_wr_data(b_m_wr_data), .m_rd(b_m_rd), .m_wr(b_m_wr),
        .m_rd_data(b_m_rd_data)
    );

    logic [31:0] b_pipe0 = JUNK;
    always @(posedge clk) b_pipe0 <= b_m_rd ? memval(b_m_addr) : JUNK;
    assign b_m_rd_data = b_pipe0;

    // ---------------- monitors ----------------
    logic [31:0] a_log_addr[$];
    int          a_log_cyc[$];
    logic [31:0] b_log_addr[$];
    int          b_log_cyc[$];
    int a_iv = 0, a_dv = 0, a_hv = 0;
    always @(negedge clk) begin
        if (a_m_rd || a_m_wr) begin
            a_log_addr.push_back(a_m_addr);
            a_log_cyc.push_back(cyc);
        end
        if (b_m_rd || b_m_wr) begin
            b_log_addr.push_back(b_m_addr);
            b_log_cyc.push_back(cyc);
        end
        if (a_i_valid) a_iv++;
        if (a_d_valid) a_dv++;
        if (a_h_valid) a_hv++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base, biv, bdv, bhv, bb;

        // ---- asynchronous reset, before any clock edge ----
        #2;
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        #1;
        chk("rst_a_ctl", 32'({a_m_rd, a_m_wr, a_i_valid, a_d_valid, a_h_valid}), 32'h0);
        chk("rst_a_maddr", a_m_addr, 32'h0);
        chk("rst_a_mwdata", a_m_wr_data, 32'h0);
        chk("rst_a_idata", a_i_data, 32'h0);
        chk("rst_a_drd", a_d_rd_data, 32'h0);
        chk("rst_a_hrd", a_h_rd_data, 32'h0);
        chk("rst_b_ctl", 32'({b_m_rd, b_m_wr, b_i_valid, b_d_valid, b_h_valid}), 32'h0);
        chk("rst_b_data", b_m_addr | b_m_wr_data | b_i_data | b_d_rd_data | b_h_rd_data, 32'h0);
        tick(2);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick(1);

        // ---- single fetch ----
        a_i_req = 1'b1; a_i_addr = 32'h100;
        tick(1);
        chk("fetch_issue", 32'({a_m_rd, a_m_wr}), 32'h2);
        chk("fetch_maddr", a_m_addr, 32'h100);
        tick(1);
        chk("fetch_wait1", 32'({a_m_rd, a_i_valid}), 32'h0);
        tick(1);
        chk("fetch_wait2", 32'({a_m_rd, a_i_valid}), 32'h0);
        tick(1);
        chk("fetch_valid", 32'(a_i_valid), 32'h1);
        chk("fetch_data", a_i_data, 32'hDEADBEEF);
        a_i_req = 1'b0;
        tick(1);
        chk("fetch_pulse_end", 32'(a_i_valid), 32'h0);
        chk("fetch_data_hold", a_i_data, 32'hDEADBEEF);

        // ---- simultaneous i / d-write / h-read ----
        biv = a_iv; bdv = a_dv; bhv = a_hv;
        a_i_req = 1'b1; a_i_addr = 32'h104;
        a_d_wr = 1'b1; a_d_addr = 32'h40; a_d_wr_data = 32'h55;
        a_h_rd = 1'b1; a_h_addr = 32'h300;
        tick(1);
        chk("sim_d_issue", 32'({a_m_rd, a_m_wr}), 32'h1);
        chk("sim_d_maddr", a_m_addr, 32'h40);
        chk("sim_d_mwdata", a_m_wr_data, 32'h55);
        tick(1);
        chk("sim_d_valid", 32'({a_i_valid, a_d_valid, a_h_valid}), 32'h2);
        a_d_wr = 1'b0;
        tick(1);
        chk("sim_gap_idle", 32'({a_m_rd, a_m_wr, a_i_valid, a_d_valid, a_h_valid}), 32'h0);
        tick(1);
        chk("sim_i_issue", 32'({a_m_rd, a_m_wr}), 32'h2);
        chk("sim_i_maddr", a_m_addr, 32'h104);
        tick(3);
        chk("sim_i_valid", 32'({a_i_valid, a_d_valid, a_h_valid}), 32'h4);
        chk("sim_i_data", a_i_data, memval(32'h104));
        a_i_req = 1'b0;
        tick(2);
        chk("sim_h_maddr", a_m_addr, 32'h300);
        chk("sim_h_issue", 32'(a_m_rd), 32'h1);
        tick(3);
        chk("sim_h_valid", 32'({a_i_valid, a_d_valid, a_h_valid}), 32'h1);
        chk("sim_h_data", a_h_rd_data, memval(32'h300));
        a_h_rd = 1'b0;
        tick(2);
        chk("sim_wr_addr", a_wr_addr, 32'h40);
        chk("sim_wr_data", a_wr_data, 32'h55);
        chk("sim_i_once", 32'(a_iv - biv), 32'd1);
        chk("sim_d_once", 32'(a_dv - bdv), 32'd1);
        chk("sim_h_once", 32'(a_hv - bhv), 32'd1);

        // ---- starvation relief ----
        base = a_log_addr.size();
        biv = a_iv; bdv = a_dv;
        a_d_rd = 1'b1; a_d_addr = 32'h200;
        a_i_req = 1'b1; a_i_addr = 32'h108;
        tick(90);
        a_d_rd = 1'b0; a_i_req = 1'b0;
        tick(8);
        chk("starve_grants", 32'(a_log_addr.size() - base), 32'd18);
        if (a_log_addr.size() - base >= 18) begin
            for (int k = 0; k < 18; k++) begin
                chk($sformatf("starve_grant%0d", k), a_log_addr[base + k],
                    (k == 8 || k == 17) ? 32'h108 : 32'h200);
            end
            chk("read_spacing", 32'(a_log_cyc[base + 1] - a_log_cyc[base]), 32'd5);
        end
        chk("starve_d_valids", 32'(a_dv - bdv), 32'd16);
        chk("starve_i_valids", 32'(a_iv - biv), 32'd2);

        // ---- request dropped in WAIT, then rd+wr conflict ----
        a_d_rd = 1'b1; a_d_addr = 32'h210;
        tick(2);
        a_d_rd = 1'b0;
        tick(2);
        chk("drop_valid", 32'(a_d_valid), 32'h1);
        chk("drop_data", a_d_rd_data, memval(32'h210));
        a_d_rd = 1'b1; a_d_wr = 1'b1; a_d_addr = 32'h44; a_d_wr_data = 32'h77;
        tick(1);
        chk("late_req_idle", 32'({a_m_rd, a_m_wr, a_d_valid}), 32'h0);
        chk("maddr_hold", a_m_addr, 32'h210);
        tick(1);
        chk("conflict_cmd", 32'({a_m_rd, a_m_wr}), 32'h1);
        chk("conflict_maddr", a_m_addr, 32'h44);
        chk("conflict_wdata", a_m_wr_data, 32'h77);
        tick(1);
        chk("conflict_valid", 32'(a_d_valid), 32'h1);
        chk("rd_data_hold", a_d_rd_data, memval(32'h210));
        a_d_rd = 1'b0; a_d_wr = 1'b0;
        tick(2);
        chk("conflict_mem_wr", a_wr_addr, 32'h44);

        // ---- reset during WAIT ----
        biv = a_iv;
        a_i_req = 1'b1; a_i_addr = 32'h120;
        tick(3);
        #1;
        a_rst_n = 1'b0;
        #1;
        chk("rst_wait_ctl", 32'({a_m_rd, a_m_wr, a_i_valid, a_d_valid, a_h_valid}), 32'h0);
        chk("rst_wait_maddr", a_m_addr, 32'h0);
        chk("rst_wait_idata", a_i_data, 32'h0);
        chk("rst_wait_drd", a_d_rd_data, 32'h0);
        tick(1);
        a_rst_n = 1'b1;
        tick(1);
        chk("rst_regrant", 32'(a_m_rd), 32'h1);
        chk("rst_regrant_addr", a_m_addr, 32'h120);
        chk("rst_no_valid", 32'(a_iv - biv), 32'd0);
        tick(3);
        chk("rst_refetch_valid", 32'(a_i_valid), 32'h1);
        chk("rst_refetch_data", a_i_data, memval(32'h120));
        a_i_req = 1'b0;
        tick(2);
        chk("rst_i_valids", 32'(a_iv - biv), 32'd1);

        // ---- MEM_LAT=1, STARVE_MAX=0 ----
        bb = b_log_addr.size();
        b_i_req = 1'b1; b_i_addr = 32'h180;
        b_d_rd = 1'b1; b_d_addr = 32'h280;
        tick(1);
        chk("l1_i_first", b_m_addr, 32'h180);
        tick(2);
        chk("l1_i_valid", 32'({b_i_valid, b_d_valid}), 32'h2);
        chk("l1_i_data", b_i_data, memval(32'h180));
        b_i_req = 1'b0;
        tick(2);
        chk("l1_d_issue", 32'(b_m_rd), 32'h1);
        chk("l1_d_maddr", b_m_addr, 32'h280);
        b_i_req = 1'b1; b_i_addr = 32'h184;
        tick(2);
        chk("l1_d_valid", 32'({b_i_valid, b_d_valid}), 32'h1);
        chk("l1_d_data", b_d_rd_data, memval(32'h280));
        tick(2);
        chk("l1_i_wins_again", b_m_addr, 32'h184);
        b_i_req = 1'b0; b_d_rd = 1'b0;
        tick(2);
        chk("l1_i2_valid", 32'(b_i_valid), 32'h1);
        chk("l1_i2_data", b_i_data, memval(32'h184));
        tick(2);
        if (b_log_addr.size() - bb >= 2) begin
            chk("l1_spacing", 32'(b_log_cyc[bb + 1] - b_log_cyc[bb]), 32'd4);
        end
        chk("l1_grants", 32'(b_log_addr.size() - bb), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
